mini_src_control_unit: RTL and testbench
========================================

Name: mini_src_control_unit

Overview:
Hardwired control sequencer for the Mini SRC datapath. It fetches each instruction and decodes the opcode in IR[31:27]. It then drives every datapath enable, bus select, ALU op and RAM strobe, one micro-step per clock (T0..T7). It sits beside the datapath, reading only the IR contents and the CON flip-flop output.

Parameters:
MEM_WAIT, 0, extra wait cycles per RAM read (0..3). ram_read is held MEM_WAIT+1 cycles; MDR latches in the last one.
HALT_ON_ILLEGAL, 0, 1: opcodes 28..31 halt; 0: they execute as nop.

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-low reset
IRout  in  32  IR contents; ra=[26:23], rb=[22:19], rc=[18:15]
CON_out  in  1  branch-condition FF output
e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_OutPort, e_InPort, e_RA, e_CON_FF  out  1 each  register enables
incPC  out  1  PC increment
ram_read, ram_write, MDR_read  out  1 each  memory strobes / MDR source select
ALU_op  out  4  ADD0 SUB1 AND2 OR3 SHR4 SHRA5 SHL6 ROR7 ROL8 MUL9 DIV10 NEG11 NOT12
BusDataSelect  out  5  R0..R15=0..15, HI16, LO17, Zhigh18, Zlow19, PC20, MDR21, InPort22
Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel  out  1 each  select/encode and ALU-B mux controls
run  out  1  0 only in HALT
instr_done  out  1  1-cycle pulse in the final step of each instruction
illegal  out  1  sticky; set on opcode 28..31

Behaviour:
- Reset: clear=0 at a rising edge sets state T0 and illegal=0. All outputs are 0 during reset, with run=1 once clear=1. Reset mid-instruction aborts it; no enable is asserted in the cycle after reset.
- Register-out convention: "Rx out" means Grx=1, e_Rout=1 and BusDataSelect = the IR field of Rx. "BA" additionally asserts BAout, so rb=0 reads as zero. "→Rx" means Grx=1 and e_Rin=1.
- Any output not named in a step is 0. Default BusDataSelect is 0.
- Fetch:
  - T0: PC→MAR, incPC.
  - T1: ram_read for MEM_WAIT+1 cycles; in the last, MDR_read=1 and e_MDR=1.
  - T2: MDR→IR.
  - T3: execute begins; IRout is valid here.
- Memory read step ("mem") behaves as T1.
- Execute by opcode:
  - ld (0): T3 Rb BA→Y; T4 imm_sel, ADD, e_Z; T5 Zlow→MAR; T6 mem; T7 MDR→Ra.
  - ldi (1): T3 Rb BA→Y; T4 imm_sel, ADD, e_Z; T5 Zlow→Ra.
  - st (2): T3–T5 as ld; T6 Ra out, ram_write.
  - add..shl (3–11): T3 Rb→Y; T4 Rc out, op, e_Z; T5 Zlow→Ra.
  - addi/andi/ori (12–14): T3 Rb→Y; T4 imm_sel, op, e_Z; T5 Zlow→Ra.
  - div/mul (15/16): T3 Ra→Y; T4 Rb out, op, e_Z; T5 Zlow→LO; T6 Zhigh→HI.
  - neg/not (17/18): T3 Rb out, op, e_Z; T4 Zlow→Ra.
  - br (19): T3 Ra out, e_RA; T4 e_CON_FF, PC→Y; T5 imm_sel, ADD, e_Z; T6 if CON_out=1, Zlow→PC, else no enables.
  - jr (20): T3 Ra out, e_PC.
  - jal (21): T3 PC→Rb; T4 Ra out, e_PC. If ra==rb, the target is the link value.
  - in (22): T3 e_InPort; T4 InPort→Ra.
  - out (23): T3 Ra out, e_OutPort.
  - mfhi/mflo (24/25): T3 HI/LO→Ra.
  - nop (26): T3 only.
  - halt (27): T3 then enter HALT.
- The final step asserts instr_done, and the next state is T0.
- HALT: all enables 0, run=0. HALT is held until clear=0.
- Illegal opcode (28..31): illegal←1 at T3. The instruction then behaves as nop, or as halt when HALT_ON_ILLEGAL=1.

Test Plan:
- Reset: clear=0 for 2 clocks mid-T4 of add, then release → T0 next; e_Rin never asserted; fetch PC=0 begins.
- Fetch/add, MEM_WAIT=0: IR=add R3,R1,R2 → T0 BusSel=20, e_MAR, incPC; T3 BusSel=1, e_Y; T4 BusSel=2, ALU_op=0, e_Z; T5 BusSel=19, Gra, e_Rin, instr_done; 6 cycles total.
- ld, MEM_WAIT=2: ram_read high 3 cycles at T1 and at T6; e_MDR only in the last of each; MDR→R[ra] at T7; instr_done after 12 cycles.
- br with CON_out=0 vs 1: e_PC asserted at T6 only when CON_out=1; e_CON_FF at T4 in both cases.
- mul: e_LO at T5 with BusSel=19, e_HI at T6 with BusSel=18; ALU_op=9 at T4.
- Opcode 30 with HALT_ON_ILLEGAL=1: illegal=1 and run=0 from the next cycle; outputs stay 0 until clear=0.

Source files
------------

// File: rtl/mini_src_control_unit_if.sv
// rtl/mini_src_control_unit_if.sv - Control bundle between the Mini SRC sequencer and its datapath
interface mini_src_control_unit_if;
  logic [31:0] IRout;
  logic        CON_out;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR;
  logic        e_OutPort, e_InPort, e_RA, e_CON_FF;
  logic        incPC, ram_read, ram_write, MDR_read;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
  logic        run, instr_done, illegal;

  modport master (
    input  IRout, CON_out,
    output e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR,
    output e_OutPort, e_InPort, e_RA, e_CON_FF,
    output incPC, ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
    output Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
    output run, instr_done, illegal
  );

  modport slave (
    output IRout, CON_out,
    input  e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR,
    input  e_OutPort, e_InPort, e_RA, e_CON_FF,
    input  incPC, ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
    input  Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
    input  run, instr_done, illegal
  );
endinterface

// File: rtl/mini_src_control_unit.sv
// rtl/mini_src_control_unit.sv - Hardwired T0..T7 control sequencer for the Mini SRC datapath
module mini_src_control_unit #(
  parameter int MEM_WAIT        = 0,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input logic                     clock,
  input logic                     clear,
  mini_src_control_unit_if.master cu
);
  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [1:0] LastWait = 2'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic [4:0] opcode, ra_sel, rb_sel, rc_sel;
  logic       unused_ir;

  assign opcode    = cu.IRout[31:27];
  assign ra_sel    = {1'b0, cu.IRout[26:23]};
  assign rb_sel    = {1'b0, cu.IRout[22:19]};
  assign rc_sel    = {1'b0, cu.IRout[18:15]};
  assign unused_ir = ^cu.IRout[14:0];

  always_comb begin
    cu.e_PC = 1'b0;  cu.e_IR = 1'b0;  cu.e_Y = 1'b0;   cu.e_Z = 1'b0;
    cu.e_HI = 1'b0;  cu.e_LO = 1'b0;  cu.e_MDR = 1'b0; cu.e_MAR = 1'b0;
    cu.e_OutPort = 1'b0; cu.e_InPort = 1'b0; cu.e_RA = 1'b0; cu.e_CON_FF = 1'b0;
    cu.incPC = 1'b0; cu.ram_read = 1'b0; cu.ram_write = 1'b0; cu.MDR_read = 1'b0;
    cu.ALU_op = 4'd0; cu.BusDataSelect = 5'd0;
    cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0;
    cu.e_Rin = 1'b0; cu.e_Rout = 1'b0; cu.BAout = 1'b0; cu.imm_sel = 1'b0;
    cu.run = 1'b0; cu.instr_done = 1'b0; cu.illegal = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;

    // Everything is forced low while clear is held, independent of state.
    if (clear) begin
      cu.run     = (state_q != S_HALT);
      cu.illegal = illegal_q;
      case (state_q)
        S_T0: begin
          cu.BusDataSelect = 5'd20; cu.e_MAR = 1'b1; cu.incPC = 1'b1;
          state_d = S_T1;
        end
        S_T1: begin
          cu.ram_read = 1'b1;
          if (wait_q == LastWait) begin
            cu.MDR_read = 1'b1; cu.e_MDR = 1'b1; wait_d = 2'd0; state_d = S_T2;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end
        S_T2: begin
          cu.BusDataSelect = 5'd21; cu.e_IR = 1'b1;
          state_d = S_T3;
        end
        S_T3: begin
          state_d = S_T4;
          case (opcode) inside
            [5'd0:5'd2]: begin
              cu.Grb = 1'b1; cu.e_Rout = 1'b1; cu.BAout = 1'b1;
              cu.BusDataSelect = rb_sel; cu.e_Y = 1'b1;
            end
            [5'd3:5'd14]: begin
              cu.Grb = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = rb_sel; cu.e_Y = 1'b1;
            end
            [5'd15:5'd16]: begin
              cu.Gra = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = ra_sel; cu.e_Y = 1'b1;
            end
            [5'd17:5'd18]: begin
              cu.Grb = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = rb_sel; cu.e_Z = 1'b1;
              cu.ALU_op = (opcode == 5'd17) ? 4'd11 : 4'd12;
            end
            5'd19: begin
              cu.Gra = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = ra_sel; cu.e_RA = 1'b1;
            end
            5'd20: begin
              cu.Gra = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = ra_sel; cu.e_PC = 1'b1;
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            5'd21: begin
              cu.BusDataSelect = 5'd20; cu.Grb = 1'b1; cu.e_Rin = 1'b1;
            end
            5'd22: cu.e_InPort = 1'b1;
            5'd23: begin
              cu.Gra = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = ra_sel; cu.e_OutPort = 1'b1;
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            [5'd24:5'd25]: begin
              cu.BusDataSelect = (opcode == 5'd24) ? 5'd16 : 5'd17;
              cu.Gra = 1'b1; cu.e_Rin = 1'b1;
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            5'd26: begin
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            5'd27: begin
              cu.instr_done = 1'b1; state_d = S_HALT;
            end
            default: begin
              illegal_d = 1'b1; cu.instr_done = 1'b1;
              state_d = HALT_ON_ILLEGAL ? S_HALT : S_T0;
            end
          endcase
        end
        S_T4: begin
          state_d = S_T5;
          case (opcode) inside
            [5'd0:5'd2]: begin
              cu.imm_sel = 1'b1; cu.ALU_op = 4'd0; cu.e_Z = 1'b1;
            end
            [5'd3:5'd11]: begin
              cu.Grc = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = rc_sel;
              cu.ALU_op = 4'(opcode - 5'd3); cu.e_Z = 1'b1;
            end
            [5'd12:5'd14]: begin
              cu.imm_sel = 1'b1; cu.e_Z = 1'b1;
              cu.ALU_op = (opcode == 5'd12) ? 4'd0 : (opcode == 5'd13) ? 4'd2 : 4'd3;
            end
            [5'd15:5'd16]: begin
              cu.Grb = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = rb_sel; cu.e_Z = 1'b1;
              cu.ALU_op = (opcode == 5'd15) ? 4'd10 : 4'd9;
            end
            [5'd17:5'd18]: begin
              cu.BusDataSelect = 5'd19; cu.Gra = 1'b1; cu.e_Rin = 1'b1;
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            5'd19: begin
              cu.e_CON_FF = 1'b1; cu.BusDataSelect = 5'd20; cu.e_Y = 1'b1;
            end
            5'd21: begin
              cu.Gra = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = ra_sel; cu.e_PC = 1'b1;
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            5'd22: begin
              cu.BusDataSelect = 5'd22; cu.Gra = 1'b1; cu.e_Rin = 1'b1;
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            default: state_d = S_T0;
          endcase
        end
        S_T5: begin
          state_d = S_T6;
          case (opcode) inside
            5'd0, 5'd2: begin
              cu.BusDataSelect = 5'd19; cu.e_MAR = 1'b1;
            end
            5'd1, [5'd3:5'd14]: begin
              cu.BusDataSelect = 5'd19; cu.Gra = 1'b1; cu.e_Rin = 1'b1;
              cu.instr_done = 1'b1; state_d = S_T0;
            end
            [5'd15:5'd16]: begin
              cu.BusDataSelect = 5'd19; cu.e_LO = 1'b1;
            end
            5'd19: begin
              cu.imm_sel = 1'b1; cu.ALU_op = 4'd0; cu.e_Z = 1'b1;
            end
            default: state_d = S_T0;
          endcase
        end
        S_T6: begin
          state_d = S_T0;
          case (opcode) inside
            5'd0: begin
              cu.ram_read = 1'b1;
              if (wait_q == LastWait) begin
                cu.MDR_read = 1'b1; cu.e_MDR = 1'b1; wait_d = 2'd0; state_d = S_T7;
              end else begin
                wait_d = wait_q + 2'd1; state_d = S_T6;
              end
            end
            5'd2: begin
              cu.Gra = 1'b1; cu.e_Rout = 1'b1; cu.BusDataSelect = ra_sel;
              cu.ram_write = 1'b1; cu.instr_done = 1'b1;
            end
            [5'd15:5'd16]: begin
              cu.BusDataSelect = 5'd18; cu.e_HI = 1'b1; cu.instr_done = 1'b1;
            end
            5'd19: begin
              if (cu.CON_out) begin
                cu.BusDataSelect = 5'd19; cu.e_PC = 1'b1;
              end
              cu.instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_T7: begin
          cu.BusDataSelect = 5'd21; cu.Gra = 1'b1; cu.e_Rin = 1'b1;
          cu.instr_done = 1'b1; state_d = S_T0;
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= S_T0;
      wait_q    <= 2'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_mini_src_control_unit.sv
// tb/tb_mini_src_control_unit.sv - Self-checking bench: two sequencer configurations against a step-list model
module tb_mini_src_control_unit;
  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  mini_src_control_unit_if ifa ();
  mini_src_control_unit_if ifb ();

  mini_src_control_unit #(.MEM_WAIT(0), .HALT_ON_ILLEGAL(1'b0)) dut_a (
    .clock(clock), .clear(clear), .cu(ifa)
  );
  mini_src_control_unit #(.MEM_WAIT(2), .HALT_ON_ILLEGAL(1'b1)) dut_b (
    .clock(clock), .clear(clear), .cu(ifb)
  );

  typedef struct packed {
    logic e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR;
    logic e_OutPort, e_InPort, e_RA, e_CON_FF;
    logic incPC, ram_read, ram_write, MDR_read;
    logic [3:0] alu;
    logic [4:0] bus;
    logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, instr_done;
  } ctl_t;

  ctl_t act_a, act_b;
  assign act_a = {ifa.e_PC, ifa.e_IR, ifa.e_Y, ifa.e_Z, ifa.e_HI, ifa.e_LO, ifa.e_MDR, ifa.e_MAR,
                  ifa.e_OutPort, ifa.e_InPort, ifa.e_RA, ifa.e_CON_FF,
                  ifa.incPC, ifa.ram_read, ifa.ram_write, ifa.MDR_read, ifa.ALU_op, ifa.BusDataSelect,
                  ifa.Gra, ifa.Grb, ifa.Grc, ifa.e_Rin, ifa.e_Rout, ifa.BAout, ifa.imm_sel, ifa.instr_done};
  assign act_b = {ifb.e_PC, ifb.e_IR, ifb.e_Y, ifb.e_Z, ifb.e_HI, ifb.e_LO, ifb.e_MDR, ifb.e_MAR,
                  ifb.e_OutPort, ifb.e_InPort, ifb.e_RA, ifb.e_CON_FF,
                  ifb.incPC, ifb.ram_read, ifb.ram_write, ifb.MDR_read, ifb.ALU_op, ifb.BusDataSelect,
                  ifb.Gra, ifb.Grb, ifb.Grc, ifb.e_Rin, ifb.e_Rout, ifb.BAout, ifb.imm_sel, ifb.instr_done};

  int   n_checks = 0;
  int   n_fail   = 0;
  ctl_t tmp_q[$], exp_a[$], exp_b[$], trace_a[$], trace_b[$];
  bit   tmp_halt, halt_a, halt_b;

  // Reference model: each instruction is a list of micro-steps, memory steps expanded by the wait count.
  function automatic ctl_t rd(input int g, input logic [31:0] ir);
    ctl_t c = '0;
    c.e_Rout = 1'b1;
    case (g)
      0: begin c.Gra = 1'b1; c.bus = {1'b0, ir[26:23]}; end
      1: begin c.Grb = 1'b1; c.bus = {1'b0, ir[22:19]}; end
      default: begin c.Grc = 1'b1; c.bus = {1'b0, ir[18:15]}; end
    endcase
    return c;
  endfunction

  function automatic ctl_t wr(input int g);
    ctl_t c = '0;
    c.e_Rin = 1'b1;
    if (g == 0) c.Gra = 1'b1; else c.Grb = 1'b1;
    return c;
  endfunction

  function automatic logic [3:0] alu_for(input int op);
    if (op >= 3 && op <= 11) return 4'(op - 3);
    case (op)
      13: return 4'd2;
      14: return 4'd3;
      15: return 4'd10;
      16: return 4'd9;
      17: return 4'd11;
      18: return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  task automatic push_mem(input int mw);
    ctl_t c;
    for (int i = 0; i <= mw; i++) begin
      c = '0; c.ram_read = 1'b1;
      if (i == mw) begin c.MDR_read = 1'b1; c.e_MDR = 1'b1; end
      tmp_q.push_back(c);
    end
  endtask

  task automatic build(input logic [31:0] ir, input logic con, input int mw, input bit hoi);
    ctl_t c;
    int op;
    op = int'(ir[31:27]);
    tmp_q.delete(); tmp_halt = 1'b0;
    c = '0; c.bus = 5'd20; c.e_MAR = 1'b1; c.incPC = 1'b1; tmp_q.push_back(c);
    push_mem(mw);
    c = '0; c.bus = 5'd21; c.e_IR = 1'b1; tmp_q.push_back(c);
    if (op <= 2) begin
      c = rd(1, ir); c.BAout = 1'b1; c.e_Y = 1'b1; tmp_q.push_back(c);
      c = '0; c.imm_sel = 1'b1; c.e_Z = 1'b1; tmp_q.push_back(c);
      if (op == 1) begin
        c = wr(0); c.bus = 5'd19; tmp_q.push_back(c);
      end else begin
        c = '0; c.bus = 5'd19; c.e_MAR = 1'b1; tmp_q.push_back(c);
        if (op == 0) begin
          push_mem(mw);
          c = wr(0); c.bus = 5'd21; tmp_q.push_back(c);
        end else begin
          c = rd(0, ir); c.ram_write = 1'b1; tmp_q.push_back(c);
        end
      end
    end else if (op <= 14) begin
      c = rd(1, ir); c.e_Y = 1'b1; tmp_q.push_back(c);
      if (op <= 11) c = rd(2, ir); else begin c = '0; c.imm_sel = 1'b1; end
      c.alu = alu_for(op); c.e_Z = 1'b1; tmp_q.push_back(c);
      c = wr(0); c.bus = 5'd19; tmp_q.push_back(c);
    end else if (op <= 16) begin
      c = rd(0, ir); c.e_Y = 1'b1; tmp_q.push_back(c);
      c = rd(1, ir); c.alu = alu_for(op); c.e_Z = 1'b1; tmp_q.push_back(c);
      c = '0; c.bus = 5'd19; c.e_LO = 1'b1; tmp_q.push_back(c);
      c = '0; c.bus = 5'd18; c.e_HI = 1'b1; tmp_q.push_back(c);
    end else if (op <= 18) begin
      c = rd(1, ir); c.alu = alu_for(op); c.e_Z = 1'b1; tmp_q.push_back(c);
      c = wr(0); c.bus = 5'd19; tmp_q.push_back(c);
    end else begin
      case (op)
        19: begin
          c = rd(0, ir); c.e_RA = 1'b1; tmp_q.push_back(c);
          c = '0; c.e_CON_FF = 1'b1; c.bus = 5'd20; c.e_Y = 1'b1; tmp_q.push_back(c);
          c = '0; c.imm_sel = 1'b1; c.e_Z = 1'b1; tmp_q.push_back(c);
          c = '0; if (con) begin c.bus = 5'd19; c.e_PC = 1'b1; end tmp_q.push_back(c);
        end
        20: begin c = rd(0, ir); c.e_PC = 1'b1; tmp_q.push_back(c); end
        21: begin
          c = wr(1); c.bus = 5'd20; tmp_q.push_back(c);
          c = rd(0, ir); c.e_PC = 1'b1; tmp_q.push_back(c);
        end
        22: begin
          c = '0; c.e_InPort = 1'b1; tmp_q.push_back(c);
          c = wr(0); c.bus = 5'd22; tmp_q.push_back(c);
        end
        23: begin c = rd(0, ir); c.e_OutPort = 1'b1; tmp_q.push_back(c); end
        24: begin c = wr(0); c.bus = 5'd16; tmp_q.push_back(c); end
        25: begin c = wr(0); c.bus = 5'd17; tmp_q.push_back(c); end
        26: begin c = '0; tmp_q.push_back(c); end
        27: begin c = '0; tmp_q.push_back(c); tmp_halt = 1'b1; end
        default: begin c = '0; tmp_q.push_back(c); tmp_halt = hoi; end
      endcase
    end
    tmp_q[tmp_q.size() - 1].instr_done = 1'b1;
  endtask

  task automatic do_reset(input logic [31:0] ir, input logic con);
    @(negedge clock); clear = 1'b0;
    repeat (2) @(negedge clock);
    ifa.IRout = ir; ifb.IRout = ir; ifa.CON_out = con; ifb.CON_out = con;
    clear = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic con);
    ctl_t a, e;
    int   idx [2];
    bit   fin [2];
    int   post [2];
    int   esz;
    bit   ill, hl;
    logic r, il;
    ill = (ir[31:27] >= 5'd28);
    build(ir, con, 0, 1'b0); exp_a = tmp_q; halt_a = tmp_halt;
    build(ir, con, 2, 1'b1); exp_b = tmp_q; halt_b = tmp_halt;
    trace_a.delete(); trace_b.delete();
    for (int d = 0; d < 2; d++) begin idx[d] = 0; fin[d] = 1'b0; post[d] = 0; end
    do_reset(ir, con);
    for (int cyc = 0; cyc < 40 && !(post[0] >= 3 && post[1] >= 3); cyc++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        a = (d == 1) ? act_b : act_a;
        if (!fin[d]) begin
          esz = (d == 1) ? exp_b.size() : exp_a.size();
          if (d == 1) trace_b.push_back(a); else trace_a.push_back(a);
          n_checks++;
          if (idx[d] < esz) begin
            e = (d == 1) ? exp_b[idx[d]] : exp_a[idx[d]];
            if (a !== e) begin
              n_fail++;
              $display("FAIL step ir=%h dut=%0d step=%0d got=%h exp=%h", ir, d, idx[d], a, e);
            end
          end else begin
            n_fail++;
            $display("FAIL overrun ir=%h dut=%0d step=%0d got=%h exp=no step", ir, d, idx[d], a);
          end
          idx[d]++;
          if (a.instr_done === 1'b1 || idx[d] >= 30) fin[d] = 1'b1;
        end else if (post[d] < 3) begin
          r  = (d == 1) ? ifb.run : ifa.run;
          il = (d == 1) ? ifb.illegal : ifa.illegal;
          hl = (d == 1) ? halt_b : halt_a;
          if (post[d] == 0) begin
            n_checks++;
            if (il !== ill) begin
              n_fail++;
              $display("FAIL illegal_flag ir=%h dut=%0d got=%b exp=%b", ir, d, il, ill);
            end
          end
          n_checks++;
          if (r !== !hl) begin
            n_fail++;
            $display("FAIL run_after ir=%h dut=%0d got=%b exp=%b", ir, d, r, !hl);
          end
          if (hl) begin
            n_checks++;
            if (a !== '0) begin
              n_fail++;
              $display("FAIL halt_quiet ir=%h dut=%0d got=%h exp=0", ir, d, a);
            end
          end
          post[d]++;
        end
      end
      @(negedge clock);
    end
    n_checks++;
    if (!(post[0] >= 3 && post[1] >= 3)) begin
      n_fail++;
      $display("FAIL timeout ir=%h got=unfinished exp=done within 40 cycles", ir);
    end
  endtask

  task automatic test_reset();
    ctl_t t0w;
    t0w = '0; t0w.bus = 5'd20; t0w.e_MAR = 1'b1; t0w.incPC = 1'b1;
    do_reset({5'd3, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0);
    repeat (4) @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (act_a !== '0 || act_b !== '0 || ifa.run !== 1'b0 || ifb.run !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_quiet cyc=%0d got=%h/%h run=%b%b exp=0", i, act_a, act_b, ifa.run, ifb.run);
      end
      @(negedge clock);
    end
    clear = 1'b1;
    #1;
    n_checks++;
    if (act_a !== t0w || act_b !== t0w) begin
      n_fail++;
      $display("FAIL reset_t0 got=%h/%h exp=%h", act_a, act_b, t0w);
    end
    n_checks++;
    if (ifa.run !== 1'b1 || ifb.run !== 1'b1 || ifa.illegal !== 1'b0 || ifb.illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got run=%b%b illegal=%b%b exp run=11 illegal=00",
               ifa.run, ifb.run, ifa.illegal, ifb.illegal);
    end
    @(negedge clock); #1;
    n_checks++;
    if (act_a.ram_read !== 1'b1 || act_a.e_Rin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fetch got ram_read=%b e_Rin=%b exp 1/0", act_a.ram_read, act_a.e_Rin);
    end
  endtask

  task automatic test_add_fetch();
    ctl_t c;
    run_instr({5'd3, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0);
    n_checks++;
    if (trace_a.size() != 6) begin
      n_fail++;
      $display("FAIL add_len got=%0d exp=6", trace_a.size());
    end else begin
      c = '0; c.bus = 5'd1; c.Grb = 1'b1; c.e_Rout = 1'b1; c.e_Y = 1'b1;
      n_checks++;
      if (trace_a[3] !== c) begin n_fail++; $display("FAIL add_t3 got=%h exp=%h", trace_a[3], c); end
      c = '0; c.bus = 5'd2; c.Grc = 1'b1; c.e_Rout = 1'b1; c.e_Z = 1'b1;
      n_checks++;
      if (trace_a[4] !== c) begin n_fail++; $display("FAIL add_t4 got=%h exp=%h", trace_a[4], c); end
      c = '0; c.bus = 5'd19; c.Gra = 1'b1; c.e_Rin = 1'b1; c.instr_done = 1'b1;
      n_checks++;
      if (trace_a[5] !== c) begin n_fail++; $display("FAIL add_t5 got=%h exp=%h", trace_a[5], c); end
    end
  endtask

  task automatic test_ld_wait();
    int rr, md;
    run_instr({5'd0, 4'd5, 4'd6, 4'd0, 15'h0010}, 1'b0);
    n_checks++;
    if (trace_b.size() != 12) begin
      n_fail++;
      $display("FAIL ld_len got=%0d exp=12", trace_b.size());
    end else begin
      rr = 0; md = 0;
      foreach (trace_b[i]) begin
        if (trace_b[i].ram_read) rr++;
        if (trace_b[i].e_MDR) md++;
      end
      n_checks++;
      if (rr != 6 || md != 2) begin
        n_fail++;
        $display("FAIL ld_mem_counts got ram_read=%0d e_MDR=%0d exp 6/2", rr, md);
      end
      n_checks++;
      if (trace_b[3].e_MDR !== 1'b1 || trace_b[10].e_MDR !== 1'b1 || trace_b[8].ram_read !== 1'b1) begin
        n_fail++;
        $display("FAIL ld_mdr_pos got t1=%b t6=%b rr8=%b exp 1/1/1",
                 trace_b[3].e_MDR, trace_b[10].e_MDR, trace_b[8].ram_read);
      end
      n_checks++;
      if (trace_b[11].bus !== 5'd21 || trace_b[11].Gra !== 1'b1 || trace_b[11].instr_done !== 1'b1) begin
        n_fail++;
        $display("FAIL ld_t7 got=%h exp bus=21 Gra done", trace_b[11]);
      end
    end
  endtask

  task automatic test_branch();
    for (int con = 0; con < 2; con++) begin
      run_instr({5'd19, 4'd2, 4'd0, 4'd0, 15'h0100}, con[0]);
      n_checks++;
      if (trace_a.size() != 7) begin
        n_fail++;
        $display("FAIL br_len con=%0d got=%0d exp=7", con, trace_a.size());
      end else begin
        n_checks++;
        if (trace_a[4].e_CON_FF !== 1'b1 || trace_a[6].e_PC !== con[0]) begin
          n_fail++;
          $display("FAIL br_pc con=%0d got con_ff=%b e_PC=%b exp 1/%0d", con,
                   trace_a[4].e_CON_FF, trace_a[6].e_PC, con);
        end
      end
    end
  endtask

  task automatic test_mul();
    run_instr({5'd16, 4'd4, 4'd7, 4'd0, 15'd0}, 1'b0);
    n_checks++;
    if (trace_a.size() != 7) begin
      n_fail++;
      $display("FAIL mul_len got=%0d exp=7", trace_a.size());
    end else begin
      n_checks++;
      if (trace_a[4].alu !== 4'd9 || trace_a[5].e_LO !== 1'b1 || trace_a[5].bus !== 5'd19
          || trace_a[6].e_HI !== 1'b1 || trace_a[6].bus !== 5'd18) begin
        n_fail++;
        $display("FAIL mul_steps got t4=%h t5=%h t6=%h exp alu9 LO@19 HI@18",
                 trace_a[4], trace_a[5], trace_a[6]);
      end
    end
  endtask

  task automatic test_illegal_halt();
    run_instr({5'd30, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0);
    n_checks++;
    if (trace_a.size() != 4 || trace_b.size() != 6) begin
      n_fail++;
      $display("FAIL illegal_len got=%0d/%0d exp=4/6", trace_a.size(), trace_b.size());
    end
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (ifb.run !== 1'b0 || ifb.illegal !== 1'b1 || act_b !== '0) begin
      n_fail++;
      $display("FAIL halt_hold got run=%b illegal=%b ctl=%h exp 0/1/0", ifb.run, ifb.illegal, act_b);
    end
    @(negedge clock); clear = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (ifb.illegal !== 1'b0 || ifa.illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_cleared got=%b%b exp=00", ifa.illegal, ifb.illegal);
    end
    @(negedge clock); clear = 1'b1; #1;
    n_checks++;
    if (ifb.run !== 1'b1 || act_b.e_MAR !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_exit got run=%b e_MAR=%b exp 1/1", ifb.run, act_b.e_MAR);
    end
  endtask

  task automatic test_random();
    logic [31:0] ir;
    for (int n = 0; n < 40; n++) begin
      ir = $urandom;
      ir[31:27] = 5'($urandom_range(0, 31));
      run_instr(ir, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    clear = 1'b0;
    ifa.IRout = '0; ifb.IRout = '0; ifa.CON_out = 1'b0; ifb.CON_out = 1'b0;
    test_reset();
    test_add_fetch();
    test_ld_wait();
    test_branch();
    test_mul();
    test_illegal_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
